// File: rtl/reg_change_tracker.sv
// Change-detection and highlight engine for the debug display: flags channels whose
// value differs from the previous cycle, with timed or sticky highlight and change statistics.
module reg_change_tracker #(
  parameter int NUM_CH      = 32,
  parameter int DATA_W      = 32,
  parameter int HOLD_CYCLES = 65535,
  parameter int CNT_W       = 16,
  parameter int IDX_W       = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH*DATA_W-1:0] data_in,
  input  logic                     mode_sticky,
  input  logic                     freeze,
  input  logic                     ack_valid,
  input  logic [IDX_W-1:0]         ack_idx,
  input  logic                     clear_all,
  output logic [NUM_CH-1:0]        changed_mask,
  output logic [IDX_W-1:0]         last_idx,
  output logic                     last_valid,
  output logic [CNT_W-1:0]         change_count,
  output logic                     multi_change
);

  localparam int HOLD_W = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam int PC_W   = $clog2(NUM_CH + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
  localparam logic [CNT_W:0]    CNT_MAX   = {1'b0, {CNT_W{1'b1}}};

  logic [DATA_W-1:0] snapshot [NUM_CH];
  logic [HOLD_W-1:0] hold_cnt [NUM_CH];
  logic              primed;

  logic [NUM_CH-1:0] chg;
  logic [PC_W-1:0]   chg_pop;
  logic [IDX_W-1:0]  chg_low;
  logic [CNT_W:0]    count_sum;

  // NOTE: combinational blocks use blocking assignments with every output defaulted
  // first, so no latch is inferred and the accumulators read their updated values.
  always_comb begin
    chg       = '0;
    chg_pop   = '0;
    chg_low   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      chg[i]  = primed && !freeze && (data_in[i*DATA_W +: DATA_W] != snapshot[i]);
      chg_pop = chg_pop + PC_W'(chg[i]);
    end
    // Scan downwards so the lowest changed channel wins.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (chg[i]) chg_low = IDX_W'(i);
    end
    count_sum = {1'b0, change_count} + (CNT_W + 1)'(chg_pop);
  end

  // NOTE: the snapshot array is reset on purpose: a zero snapshot plus the priming
  // cycle guarantees that register contents present at reset release are never flagged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        snapshot[i] <= '0;
        hold_cnt[i] <= '0;
      end
      primed       <= 1'b0;
      changed_mask <= '0;
      last_idx     <= '0;
      last_valid   <= 1'b0;
      change_count <= '0;
      multi_change <= 1'b0;
    end else if (!primed) begin
      for (int i = 0; i < NUM_CH; i++) snapshot[i] <= data_in[i*DATA_W +: DATA_W];
      primed <= 1'b1;
    end else if (!freeze) begin
      for (int i = 0; i < NUM_CH; i++) snapshot[i] <= data_in[i*DATA_W +: DATA_W];
      if (clear_all) begin
        for (int i = 0; i < NUM_CH; i++) hold_cnt[i] <= '0;
        changed_mask <= '0;
        last_idx     <= '0;
        last_valid   <= 1'b0;
        change_count <= '0;
        multi_change <= 1'b0;
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          // The hold counter runs in both modes; sticky mode just ignores it.
          if (chg[i])                    hold_cnt[i] <= HOLD_LOAD;
          else if (hold_cnt[i] != '0)    hold_cnt[i] <= hold_cnt[i] - HOLD_W'(1);

          if (chg[i])                    changed_mask[i] <= 1'b1;
          else if (mode_sticky) begin
            if (ack_valid && ack_idx == IDX_W'(i)) changed_mask[i] <= 1'b0;
          end else                       changed_mask[i] <= (hold_cnt[i] != '0);
        end
        if (|chg) begin
          last_idx   <= chg_low;
          last_valid <= 1'b1;
        end
        change_count <= (count_sum > CNT_MAX) ? {CNT_W{1'b1}} : count_sum[CNT_W-1:0];
        multi_change <= (chg_pop > PC_W'(1));
      end
    end
  end

endmodule

// File: doc/reg_change_tracker.md
Name: reg_change_tracker

Overview:
- Parametrised change-detection and highlight engine for the VGA debug path.
- Watches NUM_CH data channels, normally the register file, and flags which channels changed, with per-channel timed highlight or sticky-until-acknowledged highlight.
- Also reports the index of the last changed channel, a saturating count of change events, and a freeze control for single-step inspection.
- Sits between the register file outputs and the debug display, in the CLOCK_50 domain.

Parameters:
NUM_CH, 32, number of watched channels
DATA_W, 32, width of each channel
HOLD_CYCLES, 65535, extra cycles highlight stays high in timed mode (counter width = $clog2(HOLD_CYCLES+1), minimum 1)
CNT_W, 16, width of change_count
IDX_W, $clog2(NUM_CH), channel index width

Ports:
clk  in  1  display-domain clock (CLOCK_50)
reset_n  in  1  asynchronous active-low reset
data_in  in  NUM_CH*DATA_W  flattened channels; channel i = data_in[i*DATA_W +: DATA_W]
mode_sticky  in  1  0 = timed highlight, 1 = sticky highlight
freeze  in  1  suspends detection and snapshot update
ack_valid  in  1  clears sticky flag of channel ack_idx
ack_idx  in  IDX_W  channel to acknowledge
clear_all  in  1  synchronous clear of flags, counters, statistics
changed_mask  out  NUM_CH  per-channel highlight
last_idx  out  IDX_W  lowest channel index of the most recent change cycle
last_valid  out  1  at least one change seen since reset/clear_all
change_count  out  CNT_W  saturating count of channel-change events
multi_change  out  1  registered; more than one channel changed in previous cycle

Behaviour:
- Reset (reset_n low, async): changed_mask=0, last_idx=0, last_valid=0, change_count=0, multi_change=0; all hold counters 0; snapshot=0; primed=0.
- Priming: first clk edge after reset release loads snapshot from data_in with no change flagged. primed=1 thereafter. Non-zero register contents at reset release never light the display.
- Detection, primed and freeze=0: chg[i] = (data_in channel i != snapshot[i]). Snapshot[i] updates every cycle. Flags are registered, so 1-cycle latency from data_in change to changed_mask.
- Timed mode (mode_sticky=0), per channel:
  - if chg: cnt<=HOLD_CYCLES, mask<=1;
  - else if cnt!=0: cnt<=cnt-1, mask<=1;
  - else mask<=0.
  - Mask is high exactly HOLD_CYCLES+1 cycles after an isolated change. A re-change during hold reloads the counter.
  - HOLD_CYCLES=0 gives a 1-cycle pulse.
- Sticky mode (mode_sticky=1): chg sets mask[i]; mask[i] clears only on ack_valid with ack_idx==i, or on clear_all. Counters still run but are ignored. Set beats ack in the same cycle. ack_idx>=NUM_CH is ignored.
- Mode change sticky->timed: flags whose cnt==0 drop on the next edge.
- freeze=1: snapshot, masks, counters and statistics all hold. data_in changes are not observed. On freeze release, differences against the held snapshot are flagged on the next edge.
- Statistics:
  - change_count += popcount(chg), saturating at 2^CNT_W-1.
  - When any chg: last_idx <= lowest i with chg[i], last_valid<=1.
  - multi_change <= (popcount(chg)>1).
- clear_all: masks, counters, change_count, last_valid, last_idx, multi_change all set to 0. Snapshot still updates, so that cycle's changes are discarded. clear_all beats chg and ack.
- Reset mid-hold: all state clears immediately; the next edge after release is a priming cycle.

Test Plan:
- NUM_CH=4, DATA_W=8, HOLD_CYCLES=3; release reset with ch0=8'h55 -> no mask bit sets, change_count=0, last_valid=0.
- Timed mode: ch2 0->8'hA0 at edge k -> changed_mask=4'b0100 from edge k for exactly 4 cycles, then 0. last_idx=2, change_count=1.
- ch1 and ch3 change at edge k, ch1 changes again at k+2 -> mask[3] low after k+3, mask[1] low after k+5; multi_change=1 for one cycle; change_count=3.
- Sticky mode: ch0 changes -> mask[0] stays 1 for 100 cycles. ack_idx=0 -> cleared next edge. ack and new change on ch0 in the same cycle -> mask[0] stays 1.
- freeze=1, ch3 changes 10->20->30 -> no flag, count unchanged. freeze=0 -> mask[3]=1 next edge, change_count +1.
- CNT_W=4, force 20 single-channel changes -> change_count stops at 15. clear_all together with a ch1 change -> mask=0, count=0, and the ch1 change is not re-flagged afterwards.
